// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game sequencer.
// Decodes PS/2 make codes and steps the screen through START, COUNTDOWN, GAME,
// PAUSE and GAME_OVER. Owns the one-second prescaler, the round timer and the
// lives counter. All outputs are registered.
// Optional feature macro: GAME_FLOW_PAUSE_EN (compiles in the PAUSE state and
// the P key). When it is undefined, P is ignored and encoding 3 is unreachable.
module game_flow_ctrl #(
  parameter int unsigned TICK_DIV      = 65_000_000,
  parameter int unsigned COUNTDOWN_SEC = 3,
  parameter int unsigned ROUND_SEC     = 60,
  parameter int unsigned LIVES         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keycode,
  input  logic        key_valid,
  input  logic        player_hit,
  output logic [2:0]  screen,
  output logic [1:0]  countdown,
  output logic [6:0]  time_left,
  output logic [2:0]  lives,
  output logic        game_active,
  output logic        round_start
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_START     = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_GAME      = 3'd2,
    S_PAUSE     = 3'd3,
    S_OVER      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      countdown_q, countdown_d;
  logic [6:0]      time_left_q, time_left_d;
  logic [2:0]      lives_q, lives_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            round_start_q, round_start_d;
  logic            game_active_q;

  logic            key_event;
  logic            key_enter;
  logic            key_esc;
  logic            sec_tick;
  logic            round_over;

  // Make-code decode: a byte preceded by F0 is a break code and is ignored.
  always_comb begin
    key_event = key_valid && (keycode[15:8] != 8'hF0);
    key_enter = key_event && (keycode[7:0] == 8'h5A);
    key_esc   = key_event && (keycode[7:0] == 8'h76);
    sec_tick  = (presc_q == PRESC_MAX) &&
                ((state_q == S_COUNTDOWN) || (state_q == S_GAME));
  end

`ifdef GAME_FLOW_PAUSE_EN
  logic key_p;
  // P key decode, only present when pausing is compiled in.
  always_comb begin
    key_p = key_event && (keycode[7:0] == 8'h4D);
  end
`endif

  // Next-state and counter update logic.
  always_comb begin
    state_d       = state_q;
    countdown_d   = countdown_q;
    time_left_d   = time_left_q;
    lives_d       = lives_q;
    presc_d       = presc_q;
    round_start_d = 1'b0;
    round_over    = 1'b0;

    case (state_q)
      S_START: begin
        if (key_enter) begin
          state_d     = S_COUNTDOWN;
          countdown_d = 2'(COUNTDOWN_SEC);
          time_left_d = 7'(ROUND_SEC);
          lives_d     = 3'(LIVES);
          presc_d     = '0;
        end
      end

      S_COUNTDOWN: begin
        presc_d = sec_tick ? '0 : presc_q + 1'b1;
        if (key_esc) begin
          state_d     = S_START;
          countdown_d = '0;
        end else if (sec_tick) begin
          if (countdown_q <= 2'd1) begin
            state_d       = S_GAME;
            countdown_d   = '0;
            presc_d       = '0;
            round_start_d = 1'b1;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end
      end

      S_GAME: begin
        presc_d = sec_tick ? '0 : presc_q + 1'b1;
        // Tick and hit are both applied when they coincide; either reaching 0 ends the round.
        if (sec_tick) begin
          if (time_left_q != '0) time_left_d = time_left_q - 7'd1;
          if (time_left_q <= 7'd1) round_over = 1'b1;
        end
        if (player_hit) begin
          if (lives_q != '0) lives_d = lives_q - 3'd1;
          if (lives_q <= 3'd1) round_over = 1'b1;
        end
        if (key_esc) begin
          state_d = S_START;
        end else if (round_over) begin
          state_d = S_OVER;
`ifdef GAME_FLOW_PAUSE_EN
        end else if (key_p) begin
          state_d = S_PAUSE;
          // Freeze the prescaler where it stood so resume continues mid-second.
          if (!sec_tick) presc_d = presc_q;
`endif
        end
      end

`ifdef GAME_FLOW_PAUSE_EN
      S_PAUSE: begin
        if (key_esc) begin
          state_d = S_START;
        end else if (key_p) begin
          state_d = S_GAME;
        end
      end
`endif

      S_OVER: begin
        if (key_enter) state_d = S_START;
      end

      default: begin
        state_d = S_START;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_START;
      countdown_q   <= '0;
      time_left_q   <= 7'(ROUND_SEC);
      lives_q       <= 3'(LIVES);
      presc_q       <= '0;
      round_start_q <= 1'b0;
      game_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      countdown_q   <= countdown_d;
      time_left_q   <= time_left_d;
      lives_q       <= lives_d;
      presc_q       <= presc_d;
      round_start_q <= round_start_d;
      game_active_q <= (state_d == S_GAME);
    end
  end

  assign screen      = state_q;
  assign countdown   = countdown_q;
  assign time_left   = time_left_q;
  assign lives       = lives_q;
  assign game_active = game_active_q;
  assign round_start = round_start_q;

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer. Decodes PS/2 make codes from the keyboard receiver and steps the displayed screen through START, COUNTDOWN, GAME, PAUSE and GAME_OVER. It owns the per-second round timer and the lives counter. Its outputs select the active draw path in the VGA pipeline and gate the game-logic blocks.

## Interface
Parameters:
- TICK_DIV, 65_000_000: clk cycles per one-second tick (≥2).
- COUNTDOWN_SEC, 3: pre-round countdown length in seconds (1..3).
- ROUND_SEC, 60: round length in seconds (1..127).
- LIVES, 3: lives at round start (1..7).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- keycode  in  16  last two PS/2 bytes; [15:8] previous, [7:0] newest.
- key_valid  in  1  one-cycle strobe: a new byte was shifted into keycode.
- player_hit  in  1  one-cycle strobe from collision logic.
- screen  out  3  0=START, 1=COUNTDOWN, 2=GAME, 3=PAUSE, 4=GAME_OVER.
- countdown  out  2  seconds remaining in COUNTDOWN, else 0.
- time_left  out  7  round seconds remaining.
- lives  out  3  lives remaining.
- game_active  out  1  high only in GAME.
- round_start  out  1  one-cycle pulse on entry to GAME from COUNTDOWN.

## Operation
- Key event: key_valid=1 and keycode[15:8]≠8'hF0. Enter=8'h5A, Esc=8'h76, P=8'h4D. Break codes and all other codes are ignored.
- Prescaler: counts 0..TICK_DIV-1 in COUNTDOWN and GAME. sec_tick fires in the cycle the count equals TICK_DIV-1, then the count wraps to 0. The count is held in PAUSE and cleared on entry to COUNTDOWN and on entry to GAME.
- START: Enter moves to COUNTDOWN and loads countdown=COUNTDOWN_SEC, time_left=ROUND_SEC, lives=LIVES.
- COUNTDOWN: each sec_tick decrements countdown. A sec_tick with countdown=1 moves to GAME, sets countdown=0 and pulses round_start. Esc moves to START.
- GAME:
  - sec_tick decrements time_left; a tick with time_left=1 moves to GAME_OVER with time_left=0.
  - player_hit decrements lives; a hit with lives=1 moves to GAME_OVER with lives=0.
  - P moves to PAUSE; Esc moves to START.
- PAUSE: P moves to GAME, preserving time_left, lives and the prescaler count. Esc moves to START. player_hit is ignored.
- GAME_OVER: time_left and lives are frozen. Enter moves to START. player_hit and ticks are ignored.
- Priority when events coincide in one cycle: Esc > GAME_OVER condition > P.
  - Tick and hit in the same cycle are both applied.
  - If either one reaches 0, the next state is GAME_OVER.
- Counters saturate at 0 and never wrap.
- Undefined screen encodings (5..7) recover to START on the next cycle.

## Timing
- All outputs are registered. The state change is visible on screen the cycle after the triggering key_valid, sec_tick or player_hit.
- round_start is high for exactly the first cycle screen=2 after COUNTDOWN. Resuming from PAUSE does not pulse it.
- game_active equals (screen==2), registered together with screen.
- Reset values: screen=0, countdown=0, time_left=ROUND_SEC, lives=LIVES, game_active=0, round_start=0, prescaler=0.
- Reset asserted mid-round overrides every event in that cycle. The next cycle shows the reset values.
- The first sec_tick after entering COUNTDOWN or GAME occurs TICK_DIV cycles after entry.

## Configuration
- GAME_FLOW_PAUSE_EN defined: the PAUSE state and P handling are compiled in, as described above.
- GAME_FLOW_PAUSE_EN undefined:
  - P is ignored in every state and screen never equals 3.
  - Only Esc, timeout and lives leave GAME.
  - Encoding 3 is treated as undefined and recovers to START.

## Test plan
Run with TICK_DIV=4, COUNTDOWN_SEC=3, ROUND_SEC=5, LIVES=3.
- Reset, then Enter make (keycode 16'h005A) → screen=1, countdown=3; countdown steps 3→2→1→0 at 4-cycle intervals; screen=2 and round_start pulses once.
- In GAME with no hits → time_left steps 5→0 over 20 cycles; screen=4 the cycle after the last tick. Then Enter → screen=0.
- Three player_hit strobes in GAME → lives 3→2→1→0; screen=4 after the third hit. A hit coincident with the final tick still gives lives=2 and screen=4.
- Break sequence 8'hF0 then 8'h5A (keycode 16'hF05A) in START → screen stays 0.
- With GAME_FLOW_PAUSE_EN: P at prescaler=2 → screen=3 and time_left frozen for 20 cycles; P again → screen=2, next tick 2 cycles later, no round_start. Esc and P in the same cycle → screen=0.
- rst asserted in GAME with time_left=2 → next cycle screen=0, time_left=5, lives=3, game_active=0.
